rr_ise_pipe: RTL and testbench

Pipelined, parametrised reduced-radix ISE datapath for the x25519 / field-arithmetic accelerator path. It computes shift-and-accumulate limb operations, which are the carry-propagation primitives of reduced-radix multiprecision code, for RV32 or RV64 cores. It adds a two-stage registered pipeline with valid/ready handshaking, backpressure and flush, so the core's execute stage can issue back-to-back operations without putting a 64-bit barrel shifter and adder in one cycle. It sits between the decoder's ISE issue port and the writeback mux.

---
 rtl/rr_ise_pipe.sv | 187 ++++++++++++++++++
 tb/tb_rr_ise_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_ise_pipe.sv
// ---------------------------------------------------------------------------
// rr_ise_pipe
//
// Two-stage pipelined shift-and-accumulate unit for reduced-radix limb
// arithmetic (carry propagation in x25519-style field code). It sits between
// the ISE issue port of the decoder and the writeback mux.
//
//   S1: registers rs1, op and the shifted/masked rs2 operand.
//   S2: registers rs1 + operand and drives the response directly.
//
// Operations (modulo 2^XLEN, carry-out discarded):
//   00 SRAIADD : rd = rs1 + (rs2 >>> shamt)   sign fill from rs2[XLEN-1]
//   01 SRLIADD : rd = rs1 + (rs2 >>  shamt)   zero fill
//   10 MASKADD : rd = rs1 + (rs2 & ((1<<shamt)-1))
//   11 reserved: accepted and pipelined normally, rd = 0
//
// Parameters:
//   XLEN       datapath width, 32 or 64
//   SHW        shift-amount width, derived as $clog2(XLEN)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of every in-flight operation
//   req_valid  request present
//   req_ready  unit can accept a request this cycle
//   req_op     operation select
//   req_rs1    accumulator operand
//   req_rs2    shifted/masked operand
//   req_shamt  immediate shift amount
//   rsp_valid  result present (registered)
//   rsp_ready  consumer accepts the result
//   rsp_rd     result (registered)
// ---------------------------------------------------------------------------
module rr_ise_pipe #(
    parameter int  XLEN = 64,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [SHW-1:0]  req_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rd
);

    typedef enum logic [1:0] {
        OP_SRAIADD = 2'b00,
        OP_SRLIADD = 2'b01,
        OP_MASKADD = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic            s1_v;
    op_e             s1_op;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_opnd;

    logic            s2_v;
    logic [XLEN-1:0] s2_rd;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic s2_free;
    logic s1_adv;
    logic req_fire;
    logic rsp_fire;

    // S2 can take a new value when empty or when its current value leaves
    // this cycle; req_ready therefore only depends combinationally on
    // rsp_ready (flush deliberately does not gate it).
    assign s2_free   = !s2_v || rsp_ready;
    assign req_ready = !s1_v || s2_free;
    assign s1_adv    = s1_v && s2_free;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = s2_v && rsp_ready;

    // -----------------------------------------------------------------------
    // Log-depth shifter / mask ladder, one mux level per shamt bit.
    // keep_lvl starts all-ones and is shifted left, so its inverse at the
    // last level is the low-shamt-bits mask ((1<<shamt)-1).
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] sra_lvl  [SHW+1];
    logic [XLEN-1:0] srl_lvl  [SHW+1];
    logic [XLEN-1:0] keep_lvl [SHW+1];
    logic            sign_fill;

    assign sign_fill   = req_rs2[XLEN-1];
    assign sra_lvl[0]  = req_rs2;
    assign srl_lvl[0]  = req_rs2;
    assign keep_lvl[0] = {XLEN{1'b1}};

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_ladder
            localparam int STEP = 1 << gi;

            assign sra_lvl[gi+1] = req_shamt[gi]
                ? {{STEP{sign_fill}}, sra_lvl[gi][XLEN-1:STEP]}
                : sra_lvl[gi];

            assign srl_lvl[gi+1] = req_shamt[gi]
                ? {{STEP{1'b0}}, srl_lvl[gi][XLEN-1:STEP]}
                : srl_lvl[gi];

            assign keep_lvl[gi+1] = req_shamt[gi]
                ? {keep_lvl[gi][XLEN-1-STEP:0], {STEP{1'b0}}}
                : keep_lvl[gi];
        end
    endgenerate

    logic [XLEN-1:0] low_mask;
    assign low_mask = ~keep_lvl[SHW];

    // Operand selection for stage 1
    op_e             req_op_e;
    logic [XLEN-1:0] s1_opnd_next;

    assign req_op_e = op_e'(req_op);

    always_comb begin
        s1_opnd_next = '0;
        case (req_op_e)
            OP_SRAIADD: s1_opnd_next = sra_lvl[SHW];
            OP_SRLIADD: s1_opnd_next = srl_lvl[SHW];
            OP_MASKADD: s1_opnd_next = req_rs2 & low_mask;
            default:    s1_opnd_next = '0;
        endcase
    end

    // Stage 2 sum; reserved op forces a zero result
    logic [XLEN-1:0] s2_rd_next;
    assign s2_rd_next = (s1_op == OP_RSVD) ? '0 : (s1_rs1 + s1_opnd);

    // -----------------------------------------------------------------------
    // Stage 1 register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_op   <= OP_SRAIADD;
            s1_rs1  <= '0;
            s1_opnd <= '0;
        end else if (flush) begin
            // Flush wins over any transfer; data contents are left as-is.
            s1_v <= 1'b0;
        end else if (req_fire) begin
            s1_v    <= 1'b1;
            s1_op   <= req_op_e;
            s1_rs1  <= req_rs1;
            s1_opnd <= s1_opnd_next;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 register; holds while rsp_valid && !rsp_ready
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v  <= 1'b0;
            s2_rd <= '0;
        end else if (flush) begin
            s2_v <= 1'b0;
        end else if (s1_adv) begin
            s2_v  <= 1'b1;
            s2_rd <= s2_rd_next;
        end else if (rsp_fire) begin
            s2_v <= 1'b0;
        end
    end

    assign rsp_valid = s2_v;
    assign rsp_rd    = s2_rd;

endmodule

// File: tb/tb_rr_ise_pipe.sv
// ---------------------------------------------------------------------------
// tb_rr_ise_pipe
//
// Drives one XLEN=64 and one XLEN=32 instance with the same stimulus (the
// 32-bit one sees the low halves and low shamt bits). A transaction-level
// model (queue of expected results with acceptance times) is checked
// against both instances on every falling edge; directed tests pin the
// model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_rr_ise_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [5:0]  req_shamt = '0;
    logic        rsp_ready = 1'b1;

    logic        rdy64, rvld64, rdy32, rvld32;
    logic [63:0] rd64;
    logic [31:0] rd32;

    always #5 clk = ~clk;

    rr_ise_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy64), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_shamt(req_shamt),
        .rsp_valid(rvld64), .rsp_ready(rsp_ready), .rsp_rd(rd64)
    );

    rr_ise_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy32), .req_op(req_op),
        .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .req_shamt(req_shamt[4:0]),
        .rsp_valid(rvld32), .rsp_ready(rsp_ready), .rsp_rd(rd32)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int dut_resp = 0;   // responses handed over by dut64 (observed)

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // ---------------- reference functions ----------------
    function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int sh);
        logic signed [63:0] sa;
        logic [63:0] m;
        sa = $signed(b) >>> sh;
        m  = (64'd1 << sh) - 64'd1;
        case (op)
            2'b00:   return a + sa;
            2'b01:   return a + (b >> sh);
            2'b10:   return a + (b & m);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
        logic signed [31:0] sa;
        logic [31:0] m;
        sa = $signed(b) >>> sh;
        m  = (32'd1 << sh) - 32'd1;
        case (op)
            2'b00:   return a + sa;
            2'b01:   return a + (b >> sh);
            2'b10:   return a + (b & m);
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- model + compare process ----------------
    logic [63:0] q64[$];
    logic [31:0] q32[$];
    int          qt[$];
    int          tick = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_rd64;
    logic [31:0] prev_rd32;

    always @(negedge clk) begin
        logic exp_ready, exp_valid;
        tick++;
        if (!rst_n) begin
            q64.delete(); q32.delete(); qt.delete();
            prev_hold = 1'b0;
            chk("rst_valid64", rvld64, 1'b0);
            chk("rst_valid32", rvld32, 1'b0);
            chk("rst_ready64", rdy64, 1'b1);
            chk("rst_ready32", rdy32, 1'b1);
        end else begin
            exp_ready = (qt.size() < 2) || rsp_ready;
            exp_valid = 1'b0;
            if (qt.size() > 0) exp_valid = (tick - qt[0]) >= 2;
            chk("req_ready64", rdy64, exp_ready);
            chk("req_ready32", rdy32, exp_ready);
            chk("rsp_valid64", rvld64, exp_valid);
            chk("rsp_valid32", rvld32, exp_valid);
            if (prev_hold) begin
                chk("hold_rd64", rd64, prev_rd64);
                chk("hold_rd32", {32'd0, rd32}, {32'd0, prev_rd32});
            end
            prev_hold = rvld64 && !rsp_ready && !flush;
            prev_rd64 = rd64;
            prev_rd32 = rd32;
            if (rvld64 && rsp_ready && !flush) dut_resp++;
            if (flush) begin
                q64.delete(); q32.delete(); qt.delete();
            end else begin
                if (exp_valid && rsp_ready) begin
                    chk("rsp_rd64", rd64, q64[0]);
                    chk("rsp_rd32", {32'd0, rd32}, {32'd0, q32[0]});
                    void'(q64.pop_front());
                    void'(q32.pop_front());
                    void'(qt.pop_front());
                end
                if (req_valid && exp_ready) begin
                    q64.push_back(ref64(req_op, req_rs1, req_rs2, int'(req_shamt)));
                    q32.push_back(ref32(req_op, req_rs1[31:0], req_rs2[31:0],
                                        int'(req_shamt[4:0])));
                    qt.push_back(tick);
                end
            end
        end
    end

    // ---------------- stimulus helpers (call at posedge+1) ----------------
    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh);
        bit ok;
        req_op = op; req_rs1 = a; req_rs2 = b; req_shamt = sh;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy64) ok = 1'b1;
        end
        if (!ok) timeout_fail("send");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic basic(input string nm, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] sh,
                         input logic [63:0] e64, input logic [31:0] e32);
        rsp_ready = 1'b1;
        send(op, a, b, sh);
        @(negedge clk);
        chk({nm, "_lat1"}, rvld64, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, rvld64, 1'b1);
        chk({nm, "_rd64"}, rd64, e64);
        chk({nm, "_rd32"}, {32'd0, rd32}, {32'd0, e32});
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        // ---- reset ----
        #1 rst_n = 1'b0;
        #1;
        chk("init_ready64", rdy64, 1'b1);
        chk("init_valid64", rvld64, 1'b0);
        chk("init_rd64", rd64, 64'd0);
        chk("init_rd32", {32'd0, rd32}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- basic ops ----
        basic("sraiadd", 2'b00, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, 6'd4, 64'h0, 32'h0);
        basic("srliadd", 2'b01, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, 6'd4,
              64'h1000_0000_0000_0000, 32'h1000_0000);
        basic("maskadd", 2'b10, 64'd3, 64'h0018_0000_0000_0005, 6'd51, 64'h8, 32'h8);
        basic("mask0", 2'b10, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 64'h1234, 32'h1234);
        basic("rsvd", 2'b11, 64'h55, 64'h77, 6'd3, 64'h0, 32'h0);

        // ---- backpressure ----
        rsp_ready = 1'b0;
        base = dut_resp;
        send(2'b01, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, 6'd4);
        send(2'b00, 64'd5, 64'h100, 6'd8);
        req_op = 2'b10; req_rs1 = 64'd3; req_rs2 = 64'h0018_0000_0000_0005; req_shamt = 6'd51;
        req_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready", rdy64, 1'b0);
        chk("bp_valid", rvld64, 1'b1);
        chk("bp_rd", rd64, 64'h1000_0000_0000_0000);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", rd64, 64'h1000_0000_0000_0000);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        send(2'b10, 64'd3, 64'h0018_0000_0000_0005, 6'd51);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 64'(dut_resp - base), 64'd3);

        // ---- flush with two in flight ----
        rsp_ready = 1'b0;
        send(2'b01, 64'd1, 64'hF0, 6'd4);
        send(2'b01, 64'd2, 64'hF0, 6'd4);
        base = dut_resp;
        flush = 1'b1;
        req_op = 2'b01; req_rs1 = 64'd3; req_rs2 = 64'hF0; req_shamt = 6'd4;
        req_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("fl_valid64", rvld64, 1'b0);
        chk("fl_valid32", rvld32, 1'b0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fl_count", 64'(dut_resp - base), 64'd0);

        // ---- flush dropping a request while req_ready is high ----
        base = dut_resp;
        flush = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("fl2_ready", rdy64, 1'b1);
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("fl2_count", 64'(dut_resp - base), 64'd0);

        // ---- asynchronous reset mid-stream ----
        rsp_ready = 1'b0;
        send(2'b00, 64'd9, 64'h40, 6'd2);
        send(2'b00, 64'd8, 64'h40, 6'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid64", rvld64, 1'b0);
        chk("ar_rd64", rd64, 64'd0);
        chk("ar_rd32", {32'd0, rd32}, 64'd0);
        chk("ar_ready64", rdy64, 1'b1);
        chk("ar_ready32", rdy32, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; rsp_ready = 1'b1;
        base = dut_resp;
        repeat (4) @(posedge clk);
        #1;
        chk("ar_nores", 64'(dut_resp - base), 64'd0);
        basic("ar_resume", 2'b01, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, 6'd4,
              64'h1000_0000_0000_0000, 32'h1000_0000);

        // ---- constrained random ----
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom % 4) != 0;
            req_op    = (($urandom % 8) == 0) ? 2'b11 : 2'($urandom % 3);
            req_rs1   = {$urandom, $urandom};
            req_rs2   = {$urandom, $urandom};
            if (($urandom % 4) == 0) req_rs2[63] = 1'b1;
            if (($urandom % 4) == 0) req_rs2[31] = 1'b1;
            req_shamt = 6'($urandom);
            if (((c / 500) % 2) == 0) rsp_ready = ($urandom % 10) < 8;
            else                      rsp_ready = ($urandom % 10) < 3;
            flush = ($urandom % 60) == 0;
        end
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_valid", rvld64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
